// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 inverse-cipher core:
//   AES_NR      - number of cipher rounds (10)
//   AES_BLK_W   - block width in bits (128)
//   AES_RK      - fixed round-key schedule K[0..10] for the key
//                 000102030405060708090a0b0c0d0e0f
//   dec_state_e - decryption FSM states IDLE / ROUND / FINAL
//   round_key, inv_shift_rows, inv_mix_columns - datapath helpers
// State byte i of a 128-bit block lives in bits [127-8*i -: 8]; bytes are
// column-major, so byte index = 4*column + row.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  localparam logic [AES_BLK_W-1:0] AES_RK [0:AES_NR] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } dec_state_e;

  // Out-of-range round numbers fall back to K0; the FSM never produces them.
  function automatic logic [AES_BLK_W-1:0] round_key(input logic [3:0] rnd);
    logic [AES_BLK_W-1:0] k;
    k = AES_RK[0];
    for (int r = 0; r <= AES_NR; r++) begin
      if (rnd == 4'(r)) k = AES_RK[r];
    end
    return k;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Multiplies by 09/0b/0d/0e are built from x*2, x*4, x*8 (xtime chain).
  function automatic logic [AES_BLK_W-1:0] inv_mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a     = s[127-8*(4*c+r) -: 8];
        x2    = xtime(a);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a;
        mb[r] = x8 ^ x2 ^ a;
        md[r] = x8 ^ x4 ^ a;
        me[r] = x8 ^ x4 ^ x2;
      end
      // Circulant rows of the {0e,0b,0d,09} matrix.
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_dec_core_inv_sbox.sv
// ---------------------------------------------------------------------------
// inv_sbox
// Combinational AES inverse S-box (8-bit lookup).
//   in_i  [7:0] - input byte
//   out_o [7:0] - InvSubBytes(in_i)
// ---------------------------------------------------------------------------
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0x00 sits in the top byte, so entry a starts at bit 8*(255-a)+7.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_o = INV_SBOX[{~in_i, 3'b111} -: 8];

endmodule

// File: rtl/aes128_dec_core.sv
// ---------------------------------------------------------------------------
// aes128_dec_core
// Iterative AES-128 inverse cipher, one round per clock, fixed key schedule.
//   clk       - clock, rising edge
//   rst1      - asynchronous active-high reset
//   start     - decrypt request, accepted only while ready=1
//   data_in   - 128-bit ciphertext, sampled on the accepting edge
//   ready     - core idle
//   data_dec  - 128-bit plaintext, held until the next completion
//   decr      - one-cycle completion strobe
//   err       - sticky "start while busy" flag (only with AES_DEC_ERR_EN)
// Build option: define AES_DEC_ERR_EN to add the err port and its logic;
// without it, requests made while busy are dropped silently.
// ---------------------------------------------------------------------------
module aes128_dec_core
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst1,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] data_in,
  output logic                 ready,
  output logic [AES_BLK_W-1:0] data_dec,
  output logic                 decr
`ifdef AES_DEC_ERR_EN
  ,
  output logic                 err
`endif
);

  dec_state_e           state_q;
  logic [3:0]           rnd_q;
  logic [AES_BLK_W-1:0] st_q;
  logic [AES_BLK_W-1:0] data_dec_q;
  logic                 ready_q;
  logic                 decr_q;

  logic [AES_BLK_W-1:0] sr_d;
  logic [AES_BLK_W-1:0] sb_d;
  logic [AES_BLK_W-1:0] ark_d;
  logic [AES_BLK_W-1:0] st_d;

  // InvShiftRows only permutes bytes, so it can feed the S-boxes directly.
  assign sr_d = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    inv_sbox u_inv_sbox (
      .in_i  (sr_d[127-8*i -: 8]),
      .out_o (sb_d[127-8*i -: 8])
    );
  end

  // rnd_q is 9..1 in ROUND and 0 in FINAL, so the same key select serves
  // both; in FINAL ark_d is the plaintext.
  assign ark_d = sb_d ^ round_key(rnd_q);
  assign st_d  = inv_mix_columns(ark_d);

  always_ff @(posedge clk or posedge rst1) begin
    if (rst1) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      st_q       <= '0;
      data_dec_q <= '0;
      ready_q    <= 1'b1;
      decr_q     <= 1'b0;
    end else begin
      decr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            st_q    <= data_in ^ AES_RK[AES_NR];
            rnd_q   <= 4'(AES_NR - 1);
            ready_q <= 1'b0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          st_q  <= st_d;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) state_q <= FINAL;
        end
        FINAL: begin
          data_dec_q <= ark_d;
          decr_q     <= 1'b1;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign data_dec = data_dec_q;
  assign decr     = decr_q;

`ifdef AES_DEC_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst1) begin
    if (rst1) begin
      err_q <= 1'b0;
    end else if (start && !ready_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_aes128_dec_core.sv
// ---------------------------------------------------------------------------
// tb_aes128_dec_core
// Self-checking bench for aes128_dec_core. A forward AES-128 model (S-box
// computed from GF(2^8) inversion + affine map, key schedule expanded from
// the cipher key) produces ciphertexts; the expected plaintexts go into a
// scoreboard queue when a request is issued and are checked on each decr.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes128_dec_core;

  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst1;
  logic         start;
  logic [127:0] data_in;
  logic         ready;
  logic [127:0] data_dec;
  logic         decr;
`ifdef AES_DEC_ERR_EN
  logic         err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int decr_seen   = 0;

  logic [127:0] exp_q [$];
  logic [127:0] exp_v;
  logic [127:0] last_pt;
  logic [7:0]   sbox_t [0:255];
  logic [127:0] rk_m   [0:10];

  always #5 clk = ~clk;

  aes128_dec_core dut (
    .clk      (clk),
    .rst1     (rst1),
    .start    (start),
    .data_in  (data_in),
    .ready    (ready),
    .data_dec (data_dec),
    .decr     (decr)
`ifdef AES_DEC_ERR_EN
    ,
    .err      (err)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_model();
    logic [7:0]   inv, b;
    logic [31:0]  w [0:43];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [127:0] key;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      b = inv;
      sbox_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    key  = 128'h000102030405060708090a0b0c0d0e0f;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s, t, u, v;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_m[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          u[127-8*(4*c+q) -: 8] = t[127-8*(4*((c+q)%4)+q) -: 8];
      v = u;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[127-32*c -: 8];
          a1 = u[119-32*c -: 8];
          a2 = u[111-32*c -: 8];
          a3 = u[103-32*c -: 8];
          v[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          v[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          v[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          v[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      s = v ^ rk_m[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst1 && decr === 1'b1) begin
      decr_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_decr: data_dec=%h with no request outstanding", data_dec);
      end else begin
        exp_v = exp_q.pop_front();
        if (data_dec !== exp_v) begin
          miscompares++;
          $display("FAIL data_dec: got %h, expected %h", data_dec, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge; returns one falling edge after the
  // accepting edge.
  task automatic issue(input logic [127:0] ct, input logic [127:0] pt);
    start   = 1'b1;
    data_in = ct;
    exp_q.push_back(pt);
    last_pt = pt;
    @(negedge clk);
    start   = 1'b0;
    data_in = rand128();
  endtask

  // n0 = number of rising edges already elapsed since (and including) E1.
  task automatic wait_decr(input string tag, input int n0);
    int n;
    n = n0;
    while (decr !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (decr !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: no decr after %0d cycles, expected at 11", tag, n);
    end else begin
      if (n != 11) begin
        miscompares++;
        $display("FAIL %s_latency: decr after %0d cycles, expected 11", tag, n);
      end
      vectors++;
      if (ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_ready_at_decr: ready=%b, expected 1", tag, ready);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst1 = 1'b1; start = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (data_dec !== 128'h0) begin miscompares++; $display("FAIL reset_data_dec: got %h, expected 0", data_dec); end
    vectors++;
    if (decr !== 1'b0) begin miscompares++; $display("FAIL reset_decr: got %b, expected 0", decr); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, expected 1", ready); end
`ifdef AES_DEC_ERR_EN
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, expected 0", err); end
`endif
    rst1 = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || decr !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: ready=%b decr=%b, expected 1/0", ready, decr);
    end
  endtask

  task automatic test_fips();
    issue(FIPS_CT, FIPS_PT);
    wait_decr("fips", 1);
    @(negedge clk);
    vectors++;
    if (decr !== 1'b0) begin miscompares++; $display("FAIL fips_strobe_width: decr=%b, expected 0", decr); end
  endtask

  task automatic test_roundtrip();
    logic [127:0] pt;
    for (int k = 0; k < 6; k++) begin
      pt = (k == 0) ? FIPS_PT : rand128();
      issue(aes_enc(pt), pt);
      wait_decr("roundtrip", 1);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt2;
    pt2 = rand128();
    issue(FIPS_CT, FIPS_PT);
    wait_decr("b2b_first", 1);
    issue(FIPS_CT, FIPS_PT);
    wait_decr("b2b_second", 1);
    issue(aes_enc(pt2), pt2);
    wait_decr("b2b_third", 1);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_outstanding: %0d results never produced, expected 0", exp_q.size());
    end
  endtask

  task automatic test_busy_start();
    int base;
    base = decr_seen;
`ifdef AES_DEC_ERR_EN
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL busy_err_before: got %b, expected 0", err); end
`endif
    issue(FIPS_CT, FIPS_PT);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    data_in = '0;
    @(negedge clk);
    start   = 1'b0;
    wait_decr("busy", 6);
    repeat (20) @(negedge clk);
    vectors++;
    if (decr_seen != base + 1) begin
      miscompares++;
      $display("FAIL busy_decr_count: %0d completions, expected 1", decr_seen - base);
    end
`ifdef AES_DEC_ERR_EN
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL busy_err_sticky: got %b, expected 1", err); end
`endif
  endtask

  task automatic test_reset_midop();
    logic [127:0] pt;
    issue(FIPS_CT, FIPS_PT);
    repeat (5) @(negedge clk);
    rst1 = 1'b1;
    #1;
    exp_q.delete();
    vectors++;
    if (data_dec !== 128'h0) begin miscompares++; $display("FAIL midrst_data_dec: got %h, expected 0", data_dec); end
    vectors++;
    if (decr !== 1'b0) begin miscompares++; $display("FAIL midrst_decr: got %b, expected 0", decr); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b, expected 1", ready); end
`ifdef AES_DEC_ERR_EN
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b, expected 0", err); end
`endif
    @(negedge clk);
    rst1 = 1'b0;
    repeat (14) @(negedge clk);
    pt = rand128();
    issue(aes_enc(pt), pt);
    wait_decr("after_reset", 1);
    @(negedge clk);
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 50; i++) begin
      data_in = rand128();
      @(negedge clk);
      vectors++;
      if (data_dec !== last_pt || decr !== 1'b0 || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: data_dec=%h decr=%b ready=%b, expected %h/0/1",
                 i, data_dec, decr, ready, last_pt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst1    = 1'b1;
    start   = 1'b0;
    data_in = '0;
    last_pt = '0;
    build_model();
    test_reset();
    test_fips();
    test_roundtrip();
    test_back_to_back();
    test_busy_start();
    test_reset_midop();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
